// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map
// and the idle row pattern.
package teclado_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, HELD} estado_t;

   typedef enum logic [1:0] {DIGITO, GUARDAR, NINGUNO} clase_t;

   typedef struct packed {
      logic [3:0] codigo;
      clase_t     clase;
   } tecla_t;

   localparam logic [3:0]  FILAS_REPOSO = 4'b1111;
   localparam int unsigned N_TECLAS     = 16;

   // Indexed by {row, col}; leftmost entry is index 15 (row 3, col 3).
   localparam tecla_t [N_TECLAS-1:0] MAPA_TECLAS = '{
      '{4'hD, NINGUNO}, '{4'hF, GUARDAR}, '{4'h0, DIGITO}, '{4'hE, NINGUNO},
      '{4'hC, NINGUNO}, '{4'h9, DIGITO},  '{4'h8, DIGITO}, '{4'h7, DIGITO},
      '{4'hB, NINGUNO}, '{4'h6, DIGITO},  '{4'h5, DIGITO}, '{4'h4, DIGITO},
      '{4'hA, NINGUNO}, '{4'h3, DIGITO},  '{4'h2, DIGITO}, '{4'h1, DIGITO}
   };

   // Lowest-index low row wins when several rows are pulled down.
   function automatic logic [1:0] fila_activa(input logic [3:0] filas_s);
      logic [1:0] fila;
      fila = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!filas_s[i]) fila = 2'(i);
      end
      return fila;
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: counts 0..SCAN_DIV-1 and flags the wrap cycle.
module divisor_tick #(
   parameter int unsigned SCAN_DIV = 27000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_c
);

   localparam int unsigned      CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_c = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick_c) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: synchronizes the rows, rotates the column drive, debounces
// one key at a time and emits single-cycle push/guardar strobes.
module escaner_teclado
   import teclado_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 27000,
   parameter int unsigned DEBOUNCE_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] entrada,
   output logic       push,
   output logic       guardar
);

   localparam int unsigned      DEB_W   = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_TICKS);

   logic             tick_c;
   logic [3:0]       filas_m_q;
   logic [3:0]       filas_s_q;
   estado_t          estado_q, estado_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       fila_q, fila_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [3:0]       entrada_q, entrada_d;
   logic             push_q, push_d;
   logic             guardar_q, guardar_d;
   logic [3:0]       columnas_q;
   tecla_t           tecla;

   divisor_tick #(
      .SCAN_DIV(SCAN_DIV)
   ) u_divisor_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_c (tick_c)
   );

   assign tecla = MAPA_TECLAS[{fila_q, col_q}];

   // Strobes are computed on the transition into ACCEPT so they are visible
   // during the ACCEPT cycle itself.
   always_comb begin
      estado_d  = estado_q;
      col_d     = col_q;
      fila_d    = fila_q;
      deb_d     = deb_q;
      entrada_d = entrada_q;
      push_d    = 1'b0;
      guardar_d = 1'b0;
      case (estado_q)
         SCAN: begin
            if (tick_c) begin
               if (filas_s_q != FILAS_REPOSO) begin
                  fila_d   = fila_activa(filas_s_q);
                  deb_d    = '0;
                  estado_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (tick_c) begin
               if (!filas_s_q[fila_q]) begin
                  if (deb_q != DEB_MAX) deb_d = deb_q + DEB_W'(1);
                  if (deb_d == DEB_MAX) begin
                     estado_d = ACCEPT;
                     if (tecla.clase == DIGITO) begin
                        entrada_d = tecla.codigo;
                        push_d    = 1'b1;
                     end
                     if (tecla.clase == GUARDAR) guardar_d = 1'b1;
                  end
               end else begin
                  col_d    = col_q + 2'd1;
                  estado_d = SCAN;
               end
            end
         end
         ACCEPT: begin
            deb_d    = '0;
            estado_d = HELD;
         end
         HELD: begin
            if (tick_c) begin
               if (filas_s_q[fila_q]) begin
                  if (deb_q != DEB_MAX) deb_d = deb_q + DEB_W'(1);
               end else begin
                  deb_d = '0;
               end
               if (deb_d == DEB_MAX) begin
                  col_d    = col_q + 2'd1;
                  estado_d = SCAN;
               end
            end
         end
         default: estado_d = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filas_m_q  <= FILAS_REPOSO;
         filas_s_q  <= FILAS_REPOSO;
         estado_q   <= SCAN;
         col_q      <= 2'd0;
         fila_q     <= 2'd0;
         deb_q      <= '0;
         entrada_q  <= 4'h0;
         push_q     <= 1'b0;
         guardar_q  <= 1'b0;
         columnas_q <= 4'b1110;
      end else begin
         filas_m_q  <= filas;
         filas_s_q  <= filas_m_q;
         estado_q   <= estado_d;
         col_q      <= col_d;
         fila_q     <= fila_d;
         deb_q      <= deb_d;
         entrada_q  <= entrada_d;
         push_q     <= push_d;
         guardar_q  <= guardar_d;
         columnas_q <= ~(4'b0001 << col_d);
      end
   end

   assign columnas = columnas_q;
   assign entrada  = entrada_q;
   assign push     = push_q;
   assign guardar  = guardar_q;

endmodule

// File: tb/tb_escaner_teclado.sv
// Self-checking bench for escaner_teclado: keypad model driven by the column
// outputs, expected strobes queued at stimulus time and matched by a monitor.
module tb_escaner_teclado;

   logic       clk;
   logic       rst;
   logic [3:0] filas;
   logic [3:0] columnas;
   logic [3:0] entrada;
   logic       push;
   logic       guardar;

   logic       tecla_on;
   logic [1:0] tecla_fila;
   logic [1:0] tecla_col;

   typedef struct packed {
      logic       e_push;
      logic       e_guardar;
      logic [3:0] e_entrada;
   } esperado_t;

   esperado_t sb_q[$];
   esperado_t sb_e;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_push   = 0;
   int n_strobe = 0;
   int ciclo    = 0;
   int t_ant    = 0;
   int t_ult    = 0;

   escaner_teclado #(
      .SCAN_DIV       (4),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .filas    (filas),
      .columnas (columnas),
      .entrada  (entrada),
      .push     (push),
      .guardar  (guardar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) ciclo <= ciclo + 1;

   // Keypad: the pressed key pulls its row low only while its column is driven.
   always_comb begin
      filas = 4'hF;
      if (tecla_on && !columnas[tecla_col]) filas[tecla_fila] = 1'b0;
   end

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_tests++;
      if (obs !== esp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, esp, ciclo);
      end
   endtask

   task automatic presionar(input logic [1:0] f, input logic [1:0] c);
      tecla_fila = f;
      tecla_col  = c;
      tecla_on   = 1'b1;
   endtask

   task automatic soltar();
      tecla_on = 1'b0;
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (push || guardar) begin
         n_strobe++;
         if (push) n_push++;
         t_ant = t_ult;
         t_ult = ciclo;
         comprobar("exclusivos", 32'(push & guardar), 32'd0);
         if (sb_q.size() == 0) begin
            comprobar("strobe_extra", 32'({push, guardar}), 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            comprobar("clase", 32'({push, guardar}), 32'({sb_e.e_push, sb_e.e_guardar}));
            comprobar("entrada_strobe", 32'(entrada), 32'(sb_e.e_entrada));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] col_esp;
      int         base;
      logic       ok;

      rst      = 1'b1;
      tecla_on = 1'b0;
      tecla_fila = 2'd0;
      tecla_col  = 2'd0;
      repeat (3) @(negedge clk);
      comprobar("rst_columnas", 32'(columnas), 32'h0000_000E);
      comprobar("rst_entrada",  32'(entrada),  32'd0);
      comprobar("rst_push",     32'(push),     32'd0);
      comprobar("rst_guardar",  32'(guardar),  32'd0);

      // Idle rotation, including the 3 -> 0 wrap.
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         col_esp = ~(4'b0001 << ((k / 4) % 4));
         comprobar("columnas_rot", 32'(columnas), 32'(col_esp));
      end
      comprobar("idle_entrada", 32'(entrada), 32'd0);

      // Key 5 held 40 cycles then released.
      base = n_push;
      sb_q.push_back(esperado_t'{1'b1, 1'b0, 4'h5});
      presionar(2'd1, 2'd1);
      repeat (40) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("n_push_5",  32'(n_push - base), 32'd1);
      comprobar("entrada_5", 32'(entrada), 32'h5);
      comprobar("sb_5",      32'(sb_q.size()), 32'd0);

      // Key 7 then key 0.
      base = n_push;
      sb_q.push_back(esperado_t'{1'b1, 1'b0, 4'h7});
      presionar(2'd2, 2'd0);
      repeat (40) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("entrada_7", 32'(entrada), 32'h7);
      sb_q.push_back(esperado_t'{1'b1, 1'b0, 4'h0});
      presionar(2'd3, 2'd1);
      repeat (40) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("n_push_70",  32'(n_push - base), 32'd2);
      comprobar("entrada_0",  32'(entrada), 32'h0);
      comprobar("espaciado",  32'((t_ult - t_ant) >= 24), 32'd1);
      comprobar("sb_70",      32'(sb_q.size()), 32'd0);

      // '#' gives guardar only; 'B' gives nothing.
      base = n_strobe;
      sb_q.push_back(esperado_t'{1'b0, 1'b1, 4'h0});
      presionar(2'd3, 2'd2);
      repeat (40) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("n_strobe_hash", 32'(n_strobe - base), 32'd1);
      comprobar("sb_hash",       32'(sb_q.size()), 32'd0);
      base = n_strobe;
      presionar(2'd1, 2'd3);
      repeat (40) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("n_strobe_B", 32'(n_strobe - base), 32'd0);
      comprobar("entrada_B",  32'(entrada), 32'h0);

      // Bounce on key 3: pressed right as column 2 comes up, released after one debounce tick.
      base = n_strobe;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (columnas != 4'b1011) ok = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (columnas == 4'b1011) ok = 1'b1;
      end
      comprobar("sinc_col2", 32'(ok), 32'd1);
      presionar(2'd0, 2'd2);
      repeat (6) @(negedge clk);
      soltar();
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         if (columnas == 4'b0111) ok = 1'b1;
      end
      comprobar("rebote_avanza", 32'(ok), 32'd1);
      repeat (24) @(negedge clk);
      comprobar("n_strobe_rebote", 32'(n_strobe - base), 32'd0);

      // Key 8 held, reset mid-HELD, key re-accepted after reset.
      base = n_push;
      sb_q.push_back(esperado_t'{1'b1, 1'b0, 4'h8});
      presionar(2'd2, 2'd1);
      for (int i = 0; i < 60 && n_push == base; i++) @(negedge clk);
      comprobar("push_8_a", 32'(n_push - base), 32'd1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      comprobar("rst_mid_columnas", 32'(columnas), 32'h0000_000E);
      comprobar("rst_mid_entrada",  32'(entrada),  32'd0);
      comprobar("rst_mid_push",     32'(push),     32'd0);
      comprobar("rst_mid_guardar",  32'(guardar),  32'd0);
      rst = 1'b0;
      base = n_push;
      sb_q.push_back(esperado_t'{1'b1, 1'b0, 4'h8});
      for (int i = 0; i < 60 && n_push == base; i++) @(negedge clk);
      comprobar("push_8_b", 32'(n_push - base), 32'd1);
      repeat (20) @(negedge clk);
      soltar();
      repeat (24) @(negedge clk);
      comprobar("n_push_8_total", 32'(n_push - base), 32'd1);
      comprobar("entrada_8", 32'(entrada), 32'h8);
      comprobar("sb_8",      32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
